shell_bank: RTL and testbench
=============================

Name: shell_bank

Overview:
- Parametrised per-tank projectile pool; replaces the fixed 5-slot, per-shell-counter shell logic.
- One instance per tank, placed between the game controller (fire/vanish/game_state) and the VGA/collision logic (shell positions, active flags).
- Adds a shared movement tick, fire cooldown, automatic map-boundary expiry, fire acknowledge with slot index, and a free-slot count.

Parameters:
- N_SHELL, 5, number of shell slots.
- POS_W, 6, width of the x/y grid coordinates.
- STEP_DIV, 400000, clock cycles per one-cell shell step.
- COOLDOWN, 8, minimum cycles between two accepted fires.
- MAP_MAX, 39, highest legal coordinate on both axes; the legal range is 0..MAP_MAX.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fire  in  1  fire request, sampled every cycle
- fire_enable  in  1  game permits this tank to fire
- game_state  in  2  game controller state; 2'b10 = GS_OVER
- dir_in  in  2  tank heading: 0 up, 1 down, 2 left, 3 right
- tank_x  in  POS_W  tank x position
- tank_y  in  POS_W  tank y position
- vanish  in  N_SHELL  per-slot kill from collision logic
- shell_x  out  N_SHELL*POS_W  packed x positions, slot i at [i*POS_W +: POS_W]
- shell_y  out  N_SHELL*POS_W  packed y positions
- shell_active  out  N_SHELL  1 = slot in flight
- fire_ack  out  1  one-cycle pulse: a fire was accepted
- fire_slot  out  $clog2(N_SHELL)  index of the accepted slot; valid while fire_ack=1
- free_count  out  $clog2(N_SHELL+1)  number of inactive slots

Behaviour:
- Reset (rst=1 at posedge):
  - shell_active=0, shell_x=shell_y=0, fire_ack=0, fire_slot=0.
  - Tick counter=0, cooldown=0, latched directions=UP.
  - free_count=N_SHELL (combinational from shell_active).
- Tick counter:
  - Counts 0..STEP_DIV-1, then wraps to 0.
  - tick=1 in the cycle where count==STEP_DIV-1.
  - One counter is shared by all slots.
- Fire accept:
  - Accept = fire & fire_enable & (cooldown==0) & (any slot inactive) & (game_state!=GS_OVER).
  - Selected slot = lowest index with registered shell_active=0.
  - On the next edge: slot active=1, position=tank_x/tank_y, direction=dir_in, fire_ack=1, fire_slot=index, cooldown=COOLDOWN-1.
  - Cooldown decrements by 1 per cycle to 0 and saturates there.
  - fire held high refires every COOLDOWN cycles while slots remain.
  - A rejected fire is dropped, not queued.
- Inactive slot: position follows tank_x/tank_y every cycle, one-cycle lag.
- Active slot on tick: moves one cell in its latched direction.
  - Exception: a step that would leave 0..MAP_MAX is never taken. Instead the slot goes active=0 on that edge (UP at y=0, DOWN at y=MAP_MAX, LEFT at x=0, RIGHT at x=MAP_MAX).
  - No coordinate wrap-around is ever output.
- Vanish:
  - vanish[i]=1 on an active slot sets active=0 at the next edge.
  - Vanish has priority over a same-cycle move.
  - vanish on an inactive slot is ignored.
- Slot reuse: a slot freed this cycle is not selectable until the following cycle, because selection uses registered state.
- Simultaneous fire and vanish on different slots: both take effect.
- GS_OVER (game_state==2'b10), every cycle while asserted:
  - All slots active=0; positions track the tank.
  - Tick counter=0, cooldown=0.
  - Fire is ignored and fire_ack=0.
- Reset mid-flight: identical to power-up reset; no residual motion.

Optional Feature:
- Macro: SHELL_RANGE_EN.
- Defined:
  - Adds parameter MAX_RANGE (default 16) and a per-slot step counter, cleared on fire.
  - The slot deactivates on the tick that would make its step count exceed MAX_RANGE.
  - Boundary and vanish rules still apply; the earliest expiry wins.
- Undefined: no range counter; shells expire only on boundary, vanish, GS_OVER or reset.

Decomposition:
- shell_pkg holds:
  - dir_t enum {DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3}.
  - GS_OVER = 2'b10.
  - A lowest-free-index priority function.
- Sub-module shell_slot: one slot's active flag, latched direction, position register, boundary check and optional range counter.
- shell_bank owns the tick counter, cooldown, slot selection, fire_ack and free_count.

Test Plan (STEP_DIV=4, COOLDOWN=3, MAP_MAX=39):
- Reset, tank at (10,20), fire=1 one cycle facing RIGHT -> fire_ack=1, fire_slot=0, slot0 at (10,20); after 4 cycles (11,20), after 8 cycles (12,20).
- fire held high 20 cycles, no vanish -> acks on cycles 1,4,7,10,13 for slots 0..4; no further ack; free_count steps 5->0.
- Slot2 active, vanish[2] pulsed with fire -> slot2 inactive next edge; that fire goes to the lowest other free slot; fire next cycle past cooldown selects slot2.
- Shell fired UP at y=1 -> one tick moves it to y=0; the next tick deactivates it; y never shows 63.
- 3 shells in flight, game_state=2'b10 for 1 cycle -> all shell_active=0, free_count=5, positions equal tank position next cycle.
- Shell in flight, rst=1 one cycle -> all outputs at reset values next edge; a fire afterwards is accepted into slot 0.

Source files
------------

// File: rtl/shell_pkg.sv
// Shared types and helpers for the per-tank shell pool.
//
// Contents:
//   dir_t        - shell / tank heading encoding (up, down, left, right)
//   GS_OVER      - game_state value that freezes and clears the pool
//   MAX_SLOTS    - upper bound on slot count accepted by lowest_free()
//   lowest_free  - index of the lowest inactive slot, or n when all are busy
package shell_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [1:0] GS_OVER   = 2'b10;
  localparam int         MAX_SLOTS = 32;

  // Fixed-bound loop keeps this a plain priority encoder; bits at or above n
  // are ignored so callers can zero-extend a narrower active vector.
  function automatic int lowest_free(input logic [MAX_SLOTS-1:0] active,
                                     input int                   n);
    int idx;
    idx = n;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (i < n && !active[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/shell_slot.sv
// One projectile slot: active flag, latched heading, grid position, boundary
// expiry and (with SHELL_RANGE_EN defined) a per-flight step limit.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   clear           - game over: drop the shell, park on the tank
//   tick            - shared movement strobe from the bank
//   load            - fire accepted into this slot (only asserted while idle)
//   dir_in          - tank heading, latched on load
//   tank_x, tank_y  - tank position; idle slots track it with one-cycle lag
//   vanish          - kill request from collision logic
//   pos_x, pos_y    - slot position
//   active          - 1 while the shell is in flight
//
// Optional build macro: SHELL_RANGE_EN (adds MAX_RANGE step limit).
module shell_slot
  import shell_pkg::*;
#(
  parameter int POS_W   = 6,
  parameter int MAP_MAX = 39
`ifdef SHELL_RANGE_EN
  ,
  parameter int MAX_RANGE = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic             load,
  input  logic [1:0]       dir_in,
  input  logic [POS_W-1:0] tank_x,
  input  logic [POS_W-1:0] tank_y,
  input  logic             vanish,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             active
);

  localparam logic [POS_W-1:0] EDGE_HI = POS_W'(MAP_MAX);
  localparam logic [POS_W-1:0] ONE     = POS_W'(1);

  dir_t             dir_q;
  logic [POS_W-1:0] next_x;
  logic [POS_W-1:0] next_y;
  logic             at_edge;
  logic             expire;

  // The step that would leave the map is never computed into the position;
  // at_edge turns that tick into an expiry instead, so no wrap is visible.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    next_x  = pos_x;
    next_y  = pos_y;
    at_edge = 1'b0;
    case (dir_q)
      DIR_UP: begin
        at_edge = (pos_y == '0);
        next_y  = pos_y - ONE;
      end
      DIR_DOWN: begin
        at_edge = (pos_y == EDGE_HI);
        next_y  = pos_y + ONE;
      end
      DIR_LEFT: begin
        at_edge = (pos_x == '0);
        next_x  = pos_x - ONE;
      end
      default: begin
        at_edge = (pos_x == EDGE_HI);
        next_x  = pos_x + ONE;
      end
    endcase
  end

`ifdef SHELL_RANGE_EN
  localparam int RNG_W = $clog2(MAX_RANGE + 1);

  logic [RNG_W-1:0] steps;
  logic             range_done;

  // Reaching MAX_RANGE steps means the next tick would exceed the limit.
  assign range_done = (steps == RNG_W'(MAX_RANGE));
  assign expire     = at_edge | range_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      steps <= '0;
    end else if (load && !active) begin
      steps <= '0;
    end else if (active && !clear && !vanish && tick && !expire) begin
      steps <= steps + RNG_W'(1);
    end
  end
`else
  assign expire = at_edge;
`endif

  // Priority: reset, game over, idle tracking / load, vanish, tick.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      active <= 1'b0;
      pos_x  <= '0;
      pos_y  <= '0;
      dir_q  <= DIR_UP;
    end else if (clear) begin
      active <= 1'b0;
      pos_x  <= tank_x;
      pos_y  <= tank_y;
    end else if (!active) begin
      pos_x <= tank_x;
      pos_y <= tank_y;
      if (load) begin
        active <= 1'b1;
        dir_q  <= dir_t'(dir_in);
      end
    end else if (vanish) begin
      active <= 1'b0;
    end else if (tick) begin
      if (expire) begin
        active <= 1'b0;
      end else begin
        pos_x <= next_x;
        pos_y <= next_y;
      end
    end
  end

endmodule

// File: rtl/shell_bank.sv
// Per-tank projectile pool. Owns the shared movement tick, fire cooldown,
// lowest-free slot selection, fire acknowledge and free-slot count; each slot
// is a shell_slot instance.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   fire, fire_enable  - fire request and permission
//   game_state         - GS_OVER clears the pool every cycle it is held
//   dir_in             - tank heading (0 up, 1 down, 2 left, 3 right)
//   tank_x, tank_y     - tank grid position
//   vanish             - per-slot kill from collision logic
//   shell_x, shell_y   - packed positions, slot i at [i*POS_W +: POS_W]
//   shell_active       - per-slot in-flight flags
//   fire_ack           - one-cycle pulse when a fire is accepted
//   fire_slot          - slot index of the accepted fire
//   free_count         - number of inactive slots
//
// Optional build macro: SHELL_RANGE_EN (per-shell MAX_RANGE step limit).
module shell_bank
  import shell_pkg::*;
#(
  parameter int N_SHELL  = 5,
  parameter int POS_W    = 6,
  parameter int STEP_DIV = 400000,
  parameter int COOLDOWN = 8,
  parameter int MAP_MAX  = 39
`ifdef SHELL_RANGE_EN
  ,
  parameter int MAX_RANGE = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fire,
  input  logic                       fire_enable,
  input  logic [1:0]                 game_state,
  input  logic [1:0]                 dir_in,
  input  logic [POS_W-1:0]           tank_x,
  input  logic [POS_W-1:0]           tank_y,
  input  logic [N_SHELL-1:0]         vanish,
  output logic [N_SHELL*POS_W-1:0]   shell_x,
  output logic [N_SHELL*POS_W-1:0]   shell_y,
  output logic [N_SHELL-1:0]         shell_active,
  output logic                       fire_ack,
  output logic [$clog2(N_SHELL)-1:0] fire_slot,
  output logic [$clog2(N_SHELL+1)-1:0] free_count
);

  localparam int SEL_W  = $clog2(N_SHELL);
  localparam int FREE_W = $clog2(N_SHELL + 1);
  localparam int CNT_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CD_W   = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  logic [CNT_W-1:0]   tick_cnt;
  logic [CD_W-1:0]    cooldown;
  logic               tick;
  logic               game_over;
  logic               accept;
  int                 sel;
  logic [N_SHELL-1:0] load;

  assign game_over = (game_state == GS_OVER);
  assign tick      = (tick_cnt == CNT_W'(STEP_DIV - 1));

  // Selection sees registered flags only, so a slot freed on this edge
  // becomes selectable one cycle later.
  assign sel    = lowest_free(MAX_SLOTS'(shell_active), N_SHELL);
  assign accept = fire && fire_enable && (cooldown == '0) &&
                  !(&shell_active) && !game_over;

  always_ff @(posedge clk) begin
    if (rst || game_over) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // COOLDOWN-1 after an accept plus the accept cycle gives COOLDOWN cycles
  // between fires.
  always_ff @(posedge clk) begin
    if (rst || game_over) begin
      cooldown <= '0;
    end else if (accept) begin
      cooldown <= CD_W'(COOLDOWN - 1);
    end else if (cooldown != '0) begin
      cooldown <= cooldown - CD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fire_ack  <= 1'b0;
      fire_slot <= '0;
    end else begin
      fire_ack <= accept;
      if (accept) fire_slot <= SEL_W'(sel);
    end
  end

  for (genvar i = 0; i < N_SHELL; i++) begin : g_slot
    assign load[i] = accept && (sel == i);

    shell_slot #(
      .POS_W    (POS_W),
      .MAP_MAX  (MAP_MAX)
`ifdef SHELL_RANGE_EN
      ,
      .MAX_RANGE(MAX_RANGE)
`endif
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .clear (game_over),
      .tick  (tick),
      .load  (load[i]),
      .dir_in(dir_in),
      .tank_x(tank_x),
      .tank_y(tank_y),
      .vanish(vanish[i]),
      .pos_x (shell_x[i*POS_W +: POS_W]),
      .pos_y (shell_y[i*POS_W +: POS_W]),
      .active(shell_active[i])
    );
  end

  always_comb begin
    free_count = '0;
    for (int i = 0; i < N_SHELL; i++) begin
      if (!shell_active[i]) free_count = free_count + FREE_W'(1);
    end
  end

endmodule

// File: tb/tb_shell_bank.sv
// Directed self-checking bench for shell_bank (STEP_DIV=4, COOLDOWN=3,
// MAP_MAX=39). Expected acknowledges are queued as fires are driven and
// popped when fire_ack appears; positions and flags are checked against
// values worked out from the tick and cooldown timing.
module tb_shell_bank;

  localparam int N  = 5;
  localparam int PW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            fire;
  logic            fire_enable;
  logic [1:0]      game_state;
  logic [1:0]      dir_in;
  logic [PW-1:0]   tank_x;
  logic [PW-1:0]   tank_y;
  logic [N-1:0]    vanish;
  logic [N*PW-1:0] shell_x;
  logic [N*PW-1:0] shell_y;
  logic [N-1:0]    shell_active;
  logic            fire_ack;
  logic [2:0]      fire_slot;
  logic [2:0]      free_count;

  typedef struct {
    int slot;
    int cyc;
  } ack_t;

  ack_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  shell_bank #(
    .N_SHELL (N),
    .POS_W   (PW),
    .STEP_DIV(4),
    .COOLDOWN(3),
    .MAP_MAX (39)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fire        (fire),
    .fire_enable (fire_enable),
    .game_state  (game_state),
    .dir_in      (dir_in),
    .tank_x      (tank_x),
    .tank_y      (tank_y),
    .vanish      (vanish),
    .shell_x     (shell_x),
    .shell_y     (shell_y),
    .shell_active(shell_active),
    .fire_ack    (fire_ack),
    .fire_slot   (fire_slot),
    .free_count  (free_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int i);
    return int'(shell_x[i*PW +: PW]);
  endfunction

  function automatic int sy(input int i);
    return int'(shell_y[i*PW +: PW]);
  endfunction

  task automatic expect_ack(input int slot, input int at_cyc);
    ack_t e;
    e.slot = slot;
    e.cyc  = at_cyc;
    exp_q.push_back(e);
  endtask

  // One clock; outputs sampled 1 time unit after the edge. Any fire_ack is
  // matched against the head of the scoreboard.
  task automatic step();
    ack_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (fire_ack === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL ack_unexpected cycle=%0d slot=%0d expected no ack", cyc, fire_slot);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ack_cycle", cyc, e.cyc);
        check("ack_slot", 32'(fire_slot), e.slot);
      end
    end
  endtask

  task automatic end_test(input string tag);
    check({tag, "_ack_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_tank(input int x, input int y, input int d);
    tank_x = PW'(x);
    tank_y = PW'(y);
    dir_in = 2'(d);
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    fire       = 1'b0;
    vanish     = '0;
    game_state = 2'b00;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    rst         = 1'b1;
    fire        = 1'b0;
    fire_enable = 1'b1;
    game_state  = 2'b00;
    vanish      = '0;
    set_tank(10, 20, 3);

    // ---- 1: reset values, single fire RIGHT, movement every 4 cycles ----
    reset_dut();
    check("rst_active", 32'(shell_active), 0);
    check("rst_free", 32'(free_count), 5);
    check("rst_ack", 32'(fire_ack), 0);
    check("rst_slot", 32'(fire_slot), 0);
    check("rst_x0", sx(0), 0);
    check("rst_y0", sy(0), 0);
    fire = 1'b1;
    expect_ack(0, cyc + 1);
    step();
    fire = 1'b0;
    check("t1_active", 32'(shell_active), 1);
    check("t1_x_fire", sx(0), 10);
    check("t1_y_fire", sy(0), 20);
    step();
    step();
    check("t1_x_c3", sx(0), 10);
    step();
    check("t1_x_c4", sx(0), 11);
    check("t1_y_c4", sy(0), 20);
    for (int k = 0; k < 4; k++) step();
    check("t1_x_c8", sx(0), 12);
    end_test("t1");

    // ---- 2: fire held 20 cycles fills slots 0..4 every 3 cycles ----
    reset_dut();
    set_tank(10, 20, 3);
    fire = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 13 && (c - 1) % 3 == 0) expect_ack((c - 1) / 3, c);
      step();
      check("t2_free", 32'(free_count), 5 - ((c >= 13) ? 5 : ((c - 1) / 3 + 1)));
    end
    fire = 1'b0;
    check("t2_active", 32'(shell_active), 5'b11111);
    end_test("t2");

    // ---- 3: vanish with fire, cooldown rejects, freed-slot reuse ----
    reset_dut();
    set_tank(10, 20, 3);
    fire = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      if ((c - 1) % 3 == 0) expect_ack((c - 1) / 3, c);
      step();
    end
    fire = 1'b0;
    step();
    step();
    fire   = 1'b1;
    vanish = 5'b00100;
    expect_ack(3, 10);
    step();
    vanish = '0;
    check("t3_vanish2", 32'(shell_active), 5'b01011);
    expect_ack(2, 13);
    for (int c = 11; c <= 13; c++) step();
    fire = 1'b0;
    check("t3_reuse2", 32'(shell_active), 5'b01111);
    step();
    step();
    fire   = 1'b1;
    vanish = 5'b00001;
    expect_ack(4, 16);
    step();
    fire   = 1'b0;
    vanish = '0;
    check("t3_freed_not_sel", 32'(shell_active), 5'b11110);
    step();
    step();
    fire = 1'b1;
    expect_ack(0, 19);
    step();
    fire = 1'b0;
    check("t3_full", 32'(shell_active), 5'b11111);
    check("t3_free0", 32'(free_count), 0);
    end_test("t3");

    // ---- 4a: UP from y=1 reaches 0 then expires, never 63 ----
    reset_dut();
    set_tank(5, 1, 0);
    fire = 1'b1;
    expect_ack(0, 1);
    step();
    fire = 1'b0;
    check("t4_y_fire", sy(0), 1);
    step();
    step();
    check("t4_y_c3", sy(0), 1);
    step();
    check("t4_y_c4", sy(0), 0);
    check("t4_act_c4", 32'(shell_active[0]), 1);
    for (int c = 5; c <= 7; c++) begin
      step();
      check("t4_y_hold", sy(0), 0);
    end
    step();
    check("t4_expired", 32'(shell_active[0]), 0);
    check("t4_y_nowrap", sy(0), 0);
    step();
    check("t4_y_follow", sy(0), 1);
    end_test("t4a");

    // ---- 4b: RIGHT at x=39, DOWN at y=39, LEFT at x=0 ----
    reset_dut();
    set_tank(39, 5, 3);
    fire = 1'b1;
    expect_ack(0, 1);
    step();
    fire = 1'b0;
    check("t4b_x39", sx(0), 39);
    step();
    step();
    check("t4b_act_c3", 32'(shell_active), 5'b00001);
    set_tank(7, 39, 1);
    fire = 1'b1;
    expect_ack(1, 4);
    step();
    fire = 1'b0;
    check("t4b_right_exp", 32'(shell_active), 5'b00010);
    check("t4b_y39", sy(1), 39);
    step();
    step();
    set_tank(0, 9, 2);
    fire = 1'b1;
    expect_ack(0, 7);
    step();
    fire = 1'b0;
    check("t4b_act_c7", 32'(shell_active), 5'b00011);
    step();
    check("t4b_all_exp", 32'(shell_active), 0);
    check("t4b_x0_nowrap", sx(0), 0);
    check("t4b_y1_hold", sy(1), 39);
    end_test("t4b");

    // ---- 5: GS_OVER clears slots, cooldown and tick counter ----
    reset_dut();
    set_tank(10, 20, 3);
    fire = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      if ((c - 1) % 3 == 0) expect_ack((c - 1) / 3, c);
      step();
    end
    game_state = 2'b10;
    set_tank(3, 4, 3);
    step();
    game_state = 2'b00;
    check("t5_active", 32'(shell_active), 0);
    check("t5_free", 32'(free_count), 5);
    for (int i = 0; i < N; i++) begin
      check("t5_pos_x", sx(i), 3);
      check("t5_pos_y", sy(i), 4);
    end
    expect_ack(0, 9);
    step();
    fire = 1'b0;
    for (int c = 10; c <= 13; c++) step();
    game_state = 2'b10;
    fire       = 1'b1;
    step();
    game_state = 2'b00;
    check("t5_gs2_active", 32'(shell_active), 0);
    expect_ack(0, 15);
    step();
    fire = 1'b0;
    check("t5_x_fire", sx(0), 3);
    step();
    step();
    check("t5_x_c17", sx(0), 3);
    step();
    check("t5_x_c18", sx(0), 4);
    end_test("t5");

    // ---- 6: reset mid-flight, then fire_enable gating ----
    reset_dut();
    set_tank(10, 20, 3);
    fire = 1'b1;
    expect_ack(0, 1);
    expect_ack(1, 4);
    for (int c = 1; c <= 4; c++) step();
    fire = 1'b0;
    step();
    step();
    rst  = 1'b1;
    fire = 1'b1;
    step();
    rst  = 1'b0;
    fire = 1'b0;
    check("t6_ack", 32'(fire_ack), 0);
    check("t6_slot", 32'(fire_slot), 0);
    check("t6_active", 32'(shell_active), 0);
    check("t6_free", 32'(free_count), 5);
    check("t6_x0", sx(0), 0);
    check("t6_y0", sy(0), 0);
    check("t6_x1", sx(1), 0);
    fire = 1'b1;
    expect_ack(0, 8);
    step();
    fire = 1'b0;
    check("t6_x_fire", sx(0), 10);
    step();
    step();
    check("t6_x_c10", sx(0), 10);
    step();
    check("t6_x_c11", sx(0), 11);
    fire_enable = 1'b0;
    fire        = 1'b1;
    for (int c = 0; c < 4; c++) step();
    fire        = 1'b0;
    fire_enable = 1'b1;
    check("t6_disabled", 32'(free_count), 4);
    end_test("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
